// File: rtl/vga_scan_ctrl.sv
// Raster scan generator with a registered, blanked RGB output stage.
// DrawX/DrawY come straight from the counters; syncs, vde and RGB lag them by one pixel.
module vga_scan_ctrl #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       pix_en,
    input  logic [3:0] Red_in,
    input  logic [3:0] Green_in,
    input  logic [3:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       vde,
    output logic [3:0] Red,
    output logic [3:0] Green,
    output logic [3:0] Blue,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int HTOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VTOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(HTOT - 1);
    localparam logic [9:0] V_LAST     = 10'(VTOT - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_VIS);
    localparam logic [9:0] V_ACT_END  = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0] hc;
    logic [9:0] vc;
    logic       h_last;
    logic       v_last;
    logic       h_act;
    logic       v_act;
    logic       h_sync_n;
    logic       v_sync_n;
    logic       frame_wrap;

    assign h_last     = (hc == H_LAST);
    assign v_last     = (vc == V_LAST);
    assign frame_wrap = h_last & v_last;

    assign h_act    = (hc < H_ACT_END);
    assign v_act    = (vc < V_ACT_END);
    assign h_sync_n = ~((hc >= H_SYNC_BEG) && (hc < H_SYNC_END));
    assign v_sync_n = ~((vc >= V_SYNC_BEG) && (vc < V_SYNC_END));

    assign DrawX = hc;
    assign DrawY = vc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hc <= '0;
                vc <= v_last ? 10'd0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
        end
    end

    // Output stage: everything here describes the pixel the counters just left.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hs    <= 1'b1;
            vs    <= 1'b1;
            vde   <= 1'b0;
            Red   <= 4'h0;
            Green <= 4'h0;
            Blue  <= 4'h0;
        end else if (pix_en) begin
            hs    <= h_sync_n;
            vs    <= v_sync_n;
            vde   <= h_act & v_act;
            Red   <= (h_act & v_act) ? Red_in   : 4'h0;
            Green <= (h_act & v_act) ? Green_in : 4'h0;
            Blue  <= (h_act & v_act) ? Blue_in  : 4'h0;
        end
    end

    // frame_start is cleared on every Clk, so it never stretches across idle cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= pix_en & frame_wrap;
            if (pix_en && frame_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: a default-timing instance for line-level checks
// and a tiny-timing instance (7x6 pixel frame) for frame-level checks.
module tb_vga_scan_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       pix_en;
    logic [3:0] Red_in;
    logic [3:0] Green_in;
    logic [3:0] Blue_in;

    logic [9:0] b_x, b_y, s_x, s_y;
    logic       b_hs, b_vs, b_vde, b_fs, s_hs, s_vs, s_vde, s_fs;
    logic [3:0] b_r, b_g, b_b, s_r, s_g, s_b;
    logic [7:0] b_fc, s_fc;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [43:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 8'd0};

    wire [43:0] b_all = {b_x, b_y, b_hs, b_vs, b_vde, b_r, b_g, b_b, b_fs, b_fc};
    wire [43:0] s_all = {s_x, s_y, s_hs, s_vs, s_vde, s_r, s_g, s_b, s_fs, s_fc};

    always #5 Clk = ~Clk;

    vga_scan_ctrl dut_big (
        .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en),
        .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
        .DrawX(b_x), .DrawY(b_y), .hs(b_hs), .vs(b_vs), .vde(b_vde),
        .Red(b_r), .Green(b_g), .Blue(b_b),
        .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_scan_ctrl #(
        .H_VIS(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_small (
        .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en),
        .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
        .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .vde(s_vde),
        .Red(s_r), .Green(s_g), .Blue(s_b),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Leaves reset released just after an edge, so the next edge is the first count.
    task automatic release_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n  = 1'b0;
        pix_en   = 1'b1;
        Red_in   = 4'hF;
        Green_in = 4'h5;
        Blue_in  = 4'hA;
        repeat (3) tick();
        vectors++;
        if (b_all !== RESET_VEC) begin
            miscompares++;
            $display("[TB] FAIL reset_big actual=%h required=%h", b_all, RESET_VEC);
        end
        vectors++;
        if (s_all !== RESET_VEC) begin
            miscompares++;
            $display("[TB] FAIL reset_small actual=%h required=%h", s_all, RESET_VEC);
        end
    endtask

    // Default timing, constant F/5/A colour: first line and a bit of the second.
    task automatic test_default_line();
        int hs_low;
        logic [43:0] exp;
        logic        ehs, evde;
        logic [11:0] ergb;
        hs_low   = 0;
        pix_en   = 1'b1;
        Red_in   = 4'hF;
        Green_in = 4'h5;
        Blue_in  = 4'hA;
        release_reset();
        for (int n = 1; n <= 900; n++) begin
            tick();
            ehs  = !(((n - 1) % 800 >= 656) && ((n - 1) % 800 < 752));
            evde = ((n - 1) % 800 < 640) && ((n - 1) / 800 < 480);
            ergb = evde ? 12'hF5A : 12'h000;
            exp  = {10'(n % 800), 10'(n / 800), ehs, 1'b1, evde, ergb, 1'b0, 8'd0};
            if (!b_hs) hs_low++;
            vectors++;
            if (b_all !== exp) begin
                miscompares++;
                $display("[TB] FAIL line_n%0d actual=%h required=%h", n, b_all, exp);
            end
        end
        vectors++;
        if (hs_low != 96) begin
            miscompares++;
            $display("[TB] FAIL hs_width actual=%0d required=96", hs_low);
        end
    endtask

    // Tiny timing, 256 frames with random colour each pixel.
    task automatic test_small_frames();
        int pulses;
        int p, q;
        logic [43:0] exp;
        logic        ehs, evs, evde;
        logic [11:0] rgb_in;
        pulses = 0;
        pix_en = 1'b1;
        release_reset();
        for (int n = 1; n <= 256 * 42; n++) begin
            rgb_in   = 12'($urandom);
            Red_in   = rgb_in[11:8];
            Green_in = rgb_in[7:4];
            Blue_in  = rgb_in[3:0];
            tick();
            p    = n % 42;
            q    = (n - 1) % 42;
            ehs  = !(q % 7 == 5);
            evs  = !(q / 7 == 4);
            evde = (q % 7 < 4) && (q / 7 < 3);
            exp  = {10'(p % 7), 10'(p / 7), ehs, evs, evde,
                    (evde ? rgb_in : 12'h000), (n % 42 == 0), 8'((n / 42) % 256)};
            if (s_fs) pulses++;
            vectors++;
            if (s_all !== exp) begin
                miscompares++;
                $display("[TB] FAIL frame_n%0d actual=%h required=%h", n, s_all, exp);
            end
        end
        vectors++;
        if (pulses != 256) begin
            miscompares++;
            $display("[TB] FAIL frame_pulses actual=%0d required=256", pulses);
        end
        vectors++;
        if (s_fc !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL frame_count_wrap actual=%0d required=0", s_fc);
        end
    endtask

    // pix_en high one Clk in four: three tiny frames, pulse every 168 Clk.
    task automatic test_quarter_rate();
        int pulses, last_k, e;
        logic efs;
        pulses   = 0;
        last_k   = -1;
        pix_en   = 1'b1;
        Red_in   = 4'hF;
        Green_in = 4'h5;
        Blue_in  = 4'hA;
        release_reset();
        for (int k = 0; k < 504; k++) begin
            pix_en = (k % 4 == 0);
            tick();
            e   = k / 4 + 1;
            efs = (k % 4 == 0) && (e % 42 == 0);
            vectors++;
            if ({s_fs, s_x, s_y} !== {efs, 10'(e % 7), 10'((e % 42) / 7)}) begin
                miscompares++;
                $display("[TB] FAIL quarter_k%0d actual=%b/%0d/%0d required=%b/%0d/%0d",
                         k, s_fs, s_x, s_y, efs, e % 7, (e % 42) / 7);
            end
            if (s_fs) begin
                pulses++;
                if (last_k >= 0) begin
                    vectors++;
                    if (k - last_k != 168) begin
                        miscompares++;
                        $display("[TB] FAIL quarter_period actual=%0d required=168", k - last_k);
                    end
                end
                last_k = k;
            end
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("[TB] FAIL quarter_pulses actual=%0d required=3", pulses);
        end
    endtask

    // pix_en low for 50 Clk mid-line while the colour inputs wander.
    task automatic test_pix_en_hold();
        localparam logic [43:0] B_EXP = {10'd300, 10'd0, 1'b1, 1'b1, 1'b1, 12'hF5A, 1'b0, 8'd0};
        localparam logic [43:0] S_EXP = {10'd6, 10'd0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'd7};
        pix_en   = 1'b1;
        Red_in   = 4'hF;
        Green_in = 4'h5;
        Blue_in  = 4'hA;
        release_reset();
        repeat (300) tick();
        pix_en = 1'b0;
        for (int i = 0; i < 51; i++) begin
            vectors++;
            if (b_all !== B_EXP) begin
                miscompares++;
                $display("[TB] FAIL hold_big_i%0d actual=%h required=%h", i, b_all, B_EXP);
            end
            vectors++;
            if (s_all !== S_EXP) begin
                miscompares++;
                $display("[TB] FAIL hold_small_i%0d actual=%h required=%h", i, s_all, S_EXP);
            end
            if (i < 50) begin
                Red_in   = 4'($urandom);
                Green_in = 4'($urandom);
                Blue_in  = 4'($urandom);
                tick();
            end
        end
        Red_in   = 4'hF;
        Green_in = 4'h5;
        Blue_in  = 4'hA;
        pix_en   = 1'b1;
        tick();
        vectors++;
        if (b_x !== 10'd301) begin
            miscompares++;
            $display("[TB] FAIL hold_resume actual=%0d required=301", b_x);
        end
    endtask

    // Reset dropped between edges mid-frame, then a clean restart.
    task automatic test_async_reset();
        pix_en   = 1'b1;
        Red_in   = 4'hF;
        Green_in = 4'h5;
        Blue_in  = 4'hA;
        release_reset();
        repeat (320) tick();
        vectors++;
        if ({b_x, s_x, s_y, s_fc} !== {10'd320, 10'd5, 10'd3, 8'd7}) begin
            miscompares++;
            $display("[TB] FAIL pre_reset actual=%0d/%0d/%0d/%0d required=320/5/3/7",
                     b_x, s_x, s_y, s_fc);
        end
        #3;
        Reset_n = 1'b0;
        #1;
        vectors++;
        if (b_all !== RESET_VEC) begin
            miscompares++;
            $display("[TB] FAIL async_big actual=%h required=%h", b_all, RESET_VEC);
        end
        vectors++;
        if (s_all !== RESET_VEC) begin
            miscompares++;
            $display("[TB] FAIL async_small actual=%h required=%h", s_all, RESET_VEC);
        end
        tick();
        Reset_n = 1'b1;
        for (int n = 1; n <= 42; n++) begin
            tick();
            vectors++;
            if ({s_fs, s_fc, s_x, s_y} !== {(n == 42), 8'(n / 42), 10'(n % 7), 10'((n % 42) / 7)}) begin
                miscompares++;
                $display("[TB] FAIL restart_n%0d actual=%b/%0d/%0d/%0d required=%b/%0d/%0d/%0d",
                         n, s_fs, s_fc, s_x, s_y, (n == 42), n / 42, n % 7, (n % 42) / 7);
            end
        end
    endtask

    initial begin
        Reset_n  = 1'b0;
        pix_en   = 1'b0;
        Red_in   = 4'h0;
        Green_in = 4'h0;
        Blue_in  = 4'h0;
        test_reset();
        test_default_line();
        test_small_frames();
        test_quarter_rate();
        test_pix_en_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Purpose: raster scan generator and pixel output stage. It produces DrawX/DrawY for the color mapper, takes the mapper's combinational RGB back, and emits registered, blanked RGB with aligned syncs.

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch

REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clk, in, 1, single system clock
- Reset_n, in, 1, asynchronous active-low reset
- pix_en, in, 1, pixel strobe; all state advances only on Clk edges with pix_en=1
- Red_in / Green_in / Blue_in, in, 4 each, colour for the current DrawX/DrawY
- DrawX, out, 10, current pixel column
- DrawY, out, 10, current pixel row
- hs, out, 1, horizontal sync, active low
- vs, out, 1, vertical sync, active low
- vde, out, 1, video data enable
- Red / Green / Blue, out, 4 each, registered pixel colour
- frame_start, out, 1, one-Clk pulse at each frame wrap
- frame_count, out, 8, frame counter

Function
REQ-003 Counters:
- HTOT = H_VIS+H_FP+H_SYNC+H_BP; VTOT likewise from the V_* parameters.
- hc runs 0..HTOT-1; vc runs 0..VTOT-1.
- Both are unsigned, 10-bit.

REQ-004 Counter advance, on each Clk edge with pix_en=1:
- hc increments.
- At hc=HTOT-1: hc wraps to 0 and vc increments.
- At hc=HTOT-1 with vc=VTOT-1: both counters wrap to 0.

REQ-005 With pix_en=0, all registers SHALL hold their values.

REQ-006 DrawX=hc and DrawY=vc, driven directly from the counter registers with zero added latency. This lets the external combinational colour logic settle within the same pixel.

REQ-007 Region decode (unregistered):
- h_act = hc<H_VIS
- v_act = vc<V_VIS
- h_sync_n is low for H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC
- v_sync_n is low for V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC

REQ-008 Output stage, registered on each pix_en edge:
- hs <= h_sync_n
- vs <= v_sync_n
- vde <= h_act & v_act
- Red/Green/Blue <= *_in when h_act & v_act, else 4'h0
- All these outputs therefore lag DrawX/DrawY by exactly one pixel.

REQ-009 RGB SHALL be 0 whenever vde=0. No colour is ever driven during blanking.

REQ-010 frame_start SHALL be high for exactly one Clk cycle, following the pix_en edge at which the counters wrap from (HTOT-1, VTOT-1) to (0,0). It SHALL be low in all other cycles, including Clk cycles with pix_en=0.

REQ-011 frame_count SHALL increment on that same wrap edge, wrapping 255->0.

REQ-012 The block SHALL be sink-agnostic: no handshake, no backpressure, and no dependence on Red_in/Green_in/Blue_in other than REQ-008.

Reset
REQ-013 While Reset_n=0, asynchronously and regardless of Clk or pix_en:
- hc=0, vc=0, so DrawX=0 and DrawY=0
- hs=1, vs=1
- vde=0
- Red=Green=Blue=0
- frame_start=0
- frame_count=0

REQ-014 Assertion mid-frame SHALL abandon the frame; no partial frame_start pulse is emitted.

REQ-015 After Reset_n rises:
- The first pix_en edge SHALL register the outputs for (0,0).
- The first frame_start SHALL occur only after a complete HTOT*VTOT pixel frame.

Verification
REQ-016 Reset release, pix_en=1 continuously, default parameters:
- DrawX counts 0..799 and wraps; DrawY increments at each wrap.
- hs goes low on the edge after DrawX=656 and stays low for exactly 96 pixels.
- vs is low for exactly 2 lines, starting one pixel after (DrawX=0, DrawY=490).

REQ-017 pix_en high 1 Clk in 4:
- Counters advance every 4th Clk only.
- frame_start period = 4*800*525 = 1,680,000 Clk.
- frame_start width = 1 Clk.

REQ-018 Red_in=F, Green_in=5, Blue_in=A held constant:
- Outputs are (F,5,A) with vde=1 for exactly 640 pixels per line, on lines 0..479, delayed one pixel.
- Outputs are (0,0,0) everywhere else.

REQ-019 Reduced parameters (H 4/1/1/1, V 3/1/1/1, pix_en=1):
- Frame = 42 Clk.
- After 256 frames, frame_count has wrapped 255->0.
- Exactly 256 frame_start pulses are observed.

REQ-020 Reset_n dropped asynchronously between Clk edges at DrawX=300, DrawY=100:
- Before the next Clk edge: DrawX=DrawY=0, hs=vs=1, vde=0, RGB=0.
- After release: scan restarts from (0,0) with no spurious frame_start.

REQ-021 pix_en=0 held for 50 Clk mid-line: DrawX, DrawY, syncs, RGB and frame_count are all unchanged throughout.
